// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and flag bit positions shared by alu_core and alu_pipe.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath, WIDTH-bit operands.
// With ALU_FLAGS_EN defined it also produces {overflow, carry, negative, zero}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_opcode,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic [WIDTH-1:0] o_result
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       o_flags
`endif
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int M   = WIDTH - 1;
  localparam logic [WIDTH-1:0] LIM = WIDTH'(WIDTH);

  // Any shift amount >= WIDTH clears the result, so the full operand2 is compared
  logic           w_big;
  logic [SHW-1:0] w_sh;
  assign w_big = (i_op2 >= LIM);
  assign w_sh  = i_op2[SHW-1:0];

`ifdef ALU_FLAGS_EN
  // One extra bit on each path catches carry/borrow and the last bit shifted out
  logic [WIDTH:0] w_add, w_sub, w_shl, w_shr;
  logic           w_c, w_v;
  assign w_add = {1'b0, i_op1} + {1'b0, i_op2};
  assign w_sub = {1'b0, i_op1} - {1'b0, i_op2};
  assign w_shl = {1'b0, i_op1} << w_sh;
  assign w_shr = {i_op1, 1'b0} >> w_sh;

  // Result select plus carry/overflow per opcode
  always_comb begin
    o_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        o_result = w_add[M:0];
        w_c      = w_add[WIDTH];
        w_v      = (i_op1[M] == i_op2[M]) && (w_add[M] != i_op1[M]);
      end
      OP_SUB: begin
        o_result = w_sub[M:0];
        w_c      = w_sub[WIDTH];
        w_v      = (i_op1[M] != i_op2[M]) && (w_sub[M] != i_op1[M]);
      end
      OP_NOT: o_result = ~i_op1;
      OP_AND: o_result = i_op1 & i_op2;
      OP_OR:  o_result = i_op1 | i_op2;
      OP_XOR: o_result = i_op1 ^ i_op2;
      OP_SHL: if (!w_big) begin
        o_result = w_shl[M:0];
        w_c      = w_shl[WIDTH];
      end
      OP_SHR: if (!w_big) begin
        o_result = w_shr[WIDTH:1];
        w_c      = w_shr[0];
      end
      default: ;
    endcase
  end

  // Pack flags into their fixed bit positions
  always_comb begin
    o_flags        = '0;
    o_flags[FLG_Z] = (o_result == '0);
    o_flags[FLG_N] = o_result[M];
    o_flags[FLG_C] = w_c;
    o_flags[FLG_V] = w_v;
  end
`else
  // Result-only datapath
  always_comb begin
    o_result = '0;
    case (i_opcode)
      OP_ADD: o_result = i_op1 + i_op2;
      OP_SUB: o_result = i_op1 - i_op2;
      OP_NOT: o_result = ~i_op1;
      OP_AND: o_result = i_op1 & i_op2;
      OP_OR:  o_result = i_op1 | i_op2;
      OP_XOR: o_result = i_op1 ^ i_op2;
      OP_SHL: if (!w_big) o_result = i_op1 << w_sh;
      OP_SHR: if (!w_big) o_result = i_op1 >> w_sh;
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline around alu_core.
// s1 holds the accepted operation, s2 holds the computed result.
// Optional flags output built when ALU_FLAGS_EN is defined.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  logic             r_s1_valid, r_s2_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_result;
  logic [WIDTH-1:0] w_result;
  logic             w_s1_load, w_s2_load;

  // s2 refills whenever it is empty or its result is leaving this cycle;
  // s1 can then take a new op in the same cycle, so there is no bubble.
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;
  assign out_valid = r_s2_valid;
  assign result    = r_result;

  // s1: capture operation on the input handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= opcode;
      r_s1_a     <= operand1;
      r_s1_b     <= operand2;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

`ifdef ALU_FLAGS_EN
  logic [3:0] w_flags, r_flags;
  assign flags = r_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_opcode (r_s1_op),
    .i_op1    (r_s1_a),
    .i_op2    (r_s1_b),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // Flags travel with the result through s2
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_flags <= '0;
    else if (w_s2_load) r_flags <= w_flags;
  end
`else
  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_opcode (r_s1_op),
    .i_op1    (r_s1_a),
    .i_op2    (r_s1_b),
    .o_result (w_result)
  );
`endif

  // s2: hold result until downstream takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_result;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks on an 8-bit instance, then a randomised
// handshake run on a 32-bit instance against a reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8;
  logic [2:0] op8;
  logic [7:0] a8, b8, res8;
  logic        iv32, ir32, ov32, or32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
`ifdef ALU_FLAGS_EN
  logic [3:0] fl8, fl32;
`endif

  alu_pipe #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .opcode(op8),
    .operand1(a8), .operand2(b8), .out_valid(ov8), .out_ready(or8), .result(res8)
`ifdef ALU_FLAGS_EN
    , .flags(fl8)
`endif
  );

  alu_pipe #(.WIDTH(32)) d32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .opcode(op32),
    .operand1(a32), .operand2(b32), .out_valid(ov32), .out_ready(or32), .result(res32)
`ifdef ALU_FLAGS_EN
    , .flags(fl32)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 8-bit DUT (out_ready high) and check it two edges later
  task automatic op8_chk(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b;
    step();
    iv8 = 1'b0;
    chk({tag, "_lat1"}, ov8, 1'b0);
    step();
    chk({tag, "_vld"}, ov8, 1'b1);
    chk({tag, "_res"}, res8, er);
`ifdef ALU_FLAGS_EN
    chk({tag, "_flg"}, fl8, ef);
`else
    if (ef === 4'bxxxx) chk({tag, "_flgx"}, 1'b0, 1'b1);
`endif
  endtask

  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_NOT: return ~a;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_XOR: return a ^ b;
      OP_SHL: return (b >= 32) ? 32'd0 : a << b[4:0];
      default: return (b >= 32) ? 32'd0 : a >> b[4:0];
    endcase
  endfunction

  initial begin
    logic [31:0] q[$];
    logic [31:0] expv;
    logic        acc, del, stale;
    int          issued, got, cyc;

    rst = 1'b1;
    iv8 = 0; op8 = 0; a8 = 0; b8 = 0; or8 = 1'b1;
    iv32 = 0; op32 = 0; a32 = 0; b32 = 0; or32 = 1'b0;
    step(); step();
    chk("rst_in_ready", ir8, 1'b1);
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_result", res8, 8'd0);
`ifdef ALU_FLAGS_EN
    chk("rst_flags", fl8, 4'd0);
`endif
    rst = 1'b0;
    step();

    // flags as {V,C,N,Z}
    op8_chk("add50_25",  OP_ADD, 8'd50,  8'd25,  8'd75,  4'b0000);
    op8_chk("sub25_50",  OP_SUB, 8'd25,  8'd50,  8'd231, 4'b0110);
    op8_chk("add100_100",OP_ADD, 8'd100, 8'd100, 8'd200, 4'b1010);
    op8_chk("add_carry", OP_ADD, 8'd200, 8'd100, 8'd44,  4'b0100);
    op8_chk("shl2",      OP_SHL, 8'd50,  8'd2,   8'd200, 4'b0010);
    op8_chk("shr2",      OP_SHR, 8'd50,  8'd2,   8'd12,  4'b0100);
    op8_chk("shl9",      OP_SHL, 8'd50,  8'd9,   8'd0,   4'b0001);
    op8_chk("shl8",      OP_SHL, 8'hFF,  8'd8,   8'd0,   4'b0001);
    op8_chk("shr7",      OP_SHR, 8'h81,  8'd7,   8'd1,   4'b0000);
    op8_chk("shr0",      OP_SHR, 8'h81,  8'd0,   8'h81,  4'b0010);
    op8_chk("not50",     OP_NOT, 8'd50,  8'd9,   8'd205, 4'b0010);
    op8_chk("and",       OP_AND, 8'hF0,  8'h3C,  8'h30,  4'b0000);
    op8_chk("or",        OP_OR,  8'h0F,  8'h30,  8'h3F,  4'b0000);
    op8_chk("xor",       OP_XOR, 8'hAA,  8'hAA,  8'h00,  4'b0001);
    step();

    // Backpressure: four back-to-back adds with out_ready low
    or8 = 1'b0;
    iv8 = 1'b1; op8 = OP_ADD; a8 = 8'd1; b8 = 8'd2;   // A = 3
    #1 chk("bp_rdyA", ir8, 1'b1);
    step();
    a8 = 8'd3; b8 = 8'd4;                              // B = 7
    #1 chk("bp_rdyB", ir8, 1'b1);
    step();
    a8 = 8'd5; b8 = 8'd6;                              // C = 11
    #1 chk("bp_full_rdy", ir8, 1'b0);
    chk("bp_full_res", res8, 8'd3);
    step();
    chk("bp_hold_rdy", ir8, 1'b0);
    chk("bp_hold_vld", ov8, 1'b1);
    chk("bp_hold_res", res8, 8'd3);
    or8 = 1'b1;
    #1 chk("bp_release_rdy", ir8, 1'b1);
    step();
    chk("bp_res1", res8, 8'd7);
    a8 = 8'd7; b8 = 8'd8;                              // D = 15
    #1 chk("bp_rdyD", ir8, 1'b1);
    step();
    iv8 = 1'b0;
    chk("bp_res2", res8, 8'd11);
    step();
    chk("bp_res3", res8, 8'd15);
    chk("bp_res3_vld", ov8, 1'b1);
    step();
    chk("bp_drained", ov8, 1'b0);

    // Reset with both stages full
    or8 = 1'b0;
    iv8 = 1'b1; op8 = OP_ADD; a8 = 8'd9; b8 = 8'd9;
    step();
    a8 = 8'd10;
    step();
    iv8 = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_vld", ov8, 1'b0);
    chk("mrst_res", res8, 8'd0);
    chk("mrst_rdy", ir8, 1'b1);
    step();
    rst = 1'b0;
    or8 = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ov8) stale = 1'b1;
    end
    chk("mrst_no_stale", stale, 1'b0);

    // Randomised 32-bit run with random in_valid/out_ready
    issued = 0; got = 0; cyc = 0;
    while ((issued < 60 || q.size() != 0) && cyc < 3000) begin
      if (!iv32 && issued < 60 && $urandom_range(0, 3) != 0) begin
        iv32 = 1'b1;
        op32 = 3'($urandom_range(0, 7));
        a32  = $urandom;
        b32  = (op32 == OP_SHL || op32 == OP_SHR) ? 32'($urandom_range(0, 40)) : $urandom;
      end
      or32 = ($urandom_range(0, 3) != 0);
      #1;
      acc = iv32 && ir32;
      del = ov32 && or32;
      if (del) begin
        if (q.size() == 0) chk("r32_extra", 1'b1, 1'b0);
        else begin
          expv = q.pop_front();
          chk("r32_res", res32, expv);
          got++;
        end
      end
      if (acc) begin
        q.push_back(ref32(op32, a32, b32));
        issued++;
      end
      step();
      if (acc) iv32 = 1'b0;
      cyc++;
    end
    chk("r32_count", got, 60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
